// File: rtl/dram_mmio_pkg.sv
// rtl/dram_mmio_pkg.sv - shared MMIO decode constants and STATUS packing for dram_mmio
package dram_mmio_pkg;

   localparam int MMIO_SEL_BIT = 15;

   localparam logic [4:0] OFF_RESULT = 5'd16;
   localparam logic [4:0] OFF_STATUS = 5'd17;
   localparam logic [4:0] OFF_CLEAR  = 5'd18;

   localparam int ST_EMPTY_BIT = 0;
   localparam int ST_FULL_BIT  = 1;
   localparam int ST_OVF_BIT   = 2;
   localparam int ST_CNT_LSB   = 16;
   localparam int ST_CNT_W     = 7;

   typedef enum logic {
      REGION_RAM  = 1'b0,
      REGION_MMIO = 1'b1
   } region_e;

   function automatic logic [31:0] pack_status(input logic [ST_CNT_W-1:0] cnt,
                                               input logic ovf,
                                               input logic full,
                                               input logic empty);
      logic [31:0] s;
      s = '0;
      s[ST_CNT_LSB +: ST_CNT_W] = cnt;
      s[ST_OVF_BIT]   = ovf;
      s[ST_FULL_BIT]  = full;
      s[ST_EMPTY_BIT] = empty;
      return s;
   endfunction

endpackage

// File: rtl/res_fifo.sv
// rtl/res_fifo.sv - result FIFO, falling-edge state, power-of-2 depth with wrapping pointers
module res_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    cnt;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign count   = cnt;
   assign dout    = mem[rptr];
   assign pop_ok  = pop && !empty;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign push_ok = push && (!full || pop_ok);

   always_ff @(negedge clk) begin
      if (rst || clear) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push_ok) wptr <= wptr + AW'(1);
         if (pop_ok)  rptr <= rptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(negedge clk) begin
      if (push_ok && !rst && !clear) mem[wptr] <= din;
   end

endmodule

// File: rtl/dram_mmio.sv
// rtl/dram_mmio.sv - word RAM plus MMIO window with operand readback and a result FIFO
module dram_mmio
   import dram_mmio_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int N_OPR       = 2,
   parameter int OPR_W       = 8,
   parameter int RES_W       = 16,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [31:0]              addr,
   input  logic [31:0]              dataIn,
   input  logic [N_OPR*OPR_W-1:0]   opr,
   output logic [31:0]              dataOut,
   output logic [RES_W-1:0]         result,
   output logic                     result_valid,
   input  logic                     result_ready
);

   localparam int RAW = $clog2(DEPTH_WORDS);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]      ram [DEPTH_WORDS];
   region_e          region;
   logic [4:0]       w;
   logic [RAW-1:0]   ram_idx;
   logic             ram_wr;
   logic             mmio_wr;
   logic             push;
   logic             pop;
   logic             clr;
   logic             ovf;
   logic             full;
   logic             empty;
   logic [CW-1:0]    count;
   logic [RES_W-1:0] head;
   logic             unused_addr;

   assign region  = region_e'(addr[MMIO_SEL_BIT]);
   assign w       = addr[6:2];
   assign ram_idx = addr[2 +: RAW];
   assign unused_addr = ^addr;

   assign ram_wr  = we && (region == REGION_RAM) && !rst;
   assign mmio_wr = we && (region == REGION_MMIO);
   assign push    = mmio_wr && (w == OFF_RESULT);
   assign clr     = mmio_wr && (w == OFF_CLEAR);
   assign pop     = result_valid && result_ready;

   res_fifo #(
      .WIDTH (RES_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clr),
      .push  (push),
      .pop   (pop),
      .din   (dataIn[RES_W-1:0]),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign result_valid = !empty;
   assign result       = empty ? '0 : head;

   // Overflow is sticky until CLEAR or reset; a full FIFO that pops this edge is not overflowing.
   always_ff @(negedge clk) begin
      if (rst || clr)
         ovf <= 1'b0;
      else if (push && full && !pop)
         ovf <= 1'b1;
   end

   always_ff @(negedge clk) begin
      if (ram_wr) ram[ram_idx] <= dataIn;
   end

   always_comb begin
      dataOut = '0;
      if (region == REGION_RAM) begin
         dataOut = ram[ram_idx];
      end else begin
         for (int i = 0; i < N_OPR; i++) begin
            if (w == 5'(i)) dataOut = 32'(opr[i*OPR_W +: OPR_W]);
         end
         if (w == OFF_STATUS)
            dataOut = pack_status(ST_CNT_W'(count), ovf, full, empty);
      end
   end

endmodule

// File: tb/tb_dram_mmio.sv
// tb/tb_dram_mmio.sv - directed self-checking bench for dram_mmio
module tb_dram_mmio;

   logic        clk;
   logic        rst;
   logic        we;
   logic [31:0] addr;
   logic [31:0] dataIn;
   logic [15:0] opr;
   logic [31:0] dataOut;
   logic [15:0] result;
   logic        result_valid;
   logic        result_ready;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] A_RES  = 32'h0000_8040;
   localparam logic [31:0] A_STAT = 32'h0000_8044;
   localparam logic [31:0] A_CLR  = 32'h0000_8048;

   dram_mmio dut (
      .clk          (clk),
      .rst          (rst),
      .we           (we),
      .addr         (addr),
      .dataIn       (dataIn),
      .opr          (opr),
      .dataOut      (dataOut),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Returns just after a rising edge, so exactly one falling (active) edge has passed.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr   = a;
      dataIn = d;
      we     = 1'b1;
      tick();
      we     = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      we   = 1'b0;
      addr = a;
      #1;
      check(tag, dataOut, exp);
   endtask

   initial begin
      logic [15:0] exp_q [4];
      rst = 1'b1; we = 1'b0; addr = '0; dataIn = '0; opr = '0; result_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_valid", {31'b0, result_valid}, 32'h0);
      check("reset_result", {16'b0, result}, 32'h0);
      rd("reset_status", A_STAT, 32'h0000_0001);

      // RAM write/read and address wrap
      wr(32'h0000_0010, 32'hDEAD_BEEF);
      rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
      rd("ram_wrap", 32'h0000_0410, 32'hDEAD_BEEF);
      wr(32'h0000_03FC, 32'h1111_2222);
      rd("ram_top_wrap", 32'hFFFF_07FC, 32'h1111_2222);
      rd("ram_other", 32'h0000_0010, 32'hDEAD_BEEF);

      // operand readback
      opr = {8'hA5, 8'h3C};
      rd("opr0", 32'h0000_8000, 32'h0000_003C);
      rd("opr1", 32'h0000_8004, 32'h0000_00A5);
      rd("opr2", 32'h0000_8008, 32'h0000_0000);
      wr(32'h0000_8000, 32'hFFFF_FFFF);
      rd("opr0_ro", 32'h0000_8000, 32'h0000_003C);

      // two pushes, then drain
      wr(A_RES, 32'h0000_1234);
      check("lat1_result", {16'b0, result}, 32'h1234);
      wr(A_RES, 32'h0000_5678);
      check("two_result", {16'b0, result}, 32'h1234);
      rd("two_status", A_STAT, 32'h0002_0000);
      rd("result_rd0", A_RES, 32'h0);
      result_ready = 1'b1;
      tick();
      check("pop1_result", {16'b0, result}, 32'h5678);
      tick();
      check("pop2_valid", {31'b0, result_valid}, 32'h0);
      check("pop2_result", {16'b0, result}, 32'h0);
      result_ready = 1'b0;

      // overflow: 5 pushes into 4 entries
      for (int i = 1; i <= 5; i++) begin
         wr(A_RES, 32'(i));
         if (i == 4) rd("four_status", A_STAT, 32'h0004_0002);
      end
      rd("ovf_status", A_STAT, 32'h0004_0006);
      result_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("ovf_out%0d", i), {16'b0, result}, 32'(i));
         tick();
      end
      check("ovf_drained", {31'b0, result_valid}, 32'h0);
      rd("ovf_sticky", A_STAT, 32'h0000_0005);
      result_ready = 1'b0;
      wr(A_CLR, 32'h0);
      rd("clr_status", A_STAT, 32'h0000_0001);

      // push into a full FIFO while popping
      exp_q = '{16'h0022, 16'h0033, 16'h0044, 16'h00AA};
      wr(A_RES, 32'h11); wr(A_RES, 32'h22); wr(A_RES, 32'h33); wr(A_RES, 32'h44);
      result_ready = 1'b1;
      check("full_head", {16'b0, result}, 32'h11);
      wr(A_RES, 32'h00AA);
      result_ready = 1'b0;
      rd("pp_status", A_STAT, 32'h0004_0002);
      result_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("pp_out%0d", i), {16'b0, result}, {16'b0, exp_q[i]});
         tick();
      end
      check("pp_drained", {31'b0, result_valid}, 32'h0);
      result_ready = 1'b0;

      // CLEAR wins over a simultaneous pop
      wr(A_RES, 32'h0101); wr(A_RES, 32'h0202);
      result_ready = 1'b1;
      wr(A_CLR, 32'h0);
      result_ready = 1'b0;
      check("clr_pop_valid", {31'b0, result_valid}, 32'h0);
      rd("clr_pop_status", A_STAT, 32'h0000_0001);

      // reset with entries queued; RAM survives, push during reset is dropped
      wr(32'h0000_0020, 32'hCAFE_F00D);
      wr(A_RES, 32'h0303); wr(A_RES, 32'h0404);
      rd("pre_rst_status", A_STAT, 32'h0002_0000);
      rst = 1'b1;
      wr(A_RES, 32'h0505);
      rst = 1'b0;
      check("rst_valid", {31'b0, result_valid}, 32'h0);
      check("rst_result", {16'b0, result}, 32'h0);
      rd("rst_status", A_STAT, 32'h0000_0001);
      rd("rst_ram", 32'h0000_0020, 32'hCAFE_F00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dram_mmio.md
DRAM_MMIO -- requirements
Module: dram_mmio

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, RAM size in 32-bit words (power of 2, 16..4096).
REQ-002 SHALL have parameter N_OPR, default 2, operand channel count (1..8).
REQ-003 SHALL have parameter OPR_W, default 8, operand width (1..32).
REQ-004 SHALL have parameter RES_W, default 16, result width (1..32).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of 2, 2..64).
REQ-006 SHALL have port clk  in  1  single clock.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port we  in  1  write enable.
REQ-009 SHALL have port addr  in  32  byte address.
REQ-010 SHALL have port dataIn  in  32  write data.
REQ-011 SHALL have port opr  in  N_OPR*OPR_W  operand channels, channel i at bits [i*OPR_W +: OPR_W].
REQ-012 SHALL have port dataOut  out  32  read data.
REQ-013 SHALL have port result  out  RES_W  FIFO head.
REQ-014 SHALL have port result_valid  out  1  FIFO non-empty.
REQ-015 SHALL have port result_ready  in  1  consumer accepts head.

Function
REQ-016 SHALL update all state on the falling edge of clk; reads are combinational.
REQ-017 SHALL decode addr[15]=0 as RAM, word index addr[2 +: log2(DEPTH_WORDS)]; upper bits ignored (wrap).
REQ-018 SHALL decode addr[15]=1 as MMIO, word offset w = addr[6:2].
REQ-019 SHALL, for a RAM write (we=1), store the full dataIn word; a RAM read returns the stored word.
REQ-020 SHALL, for MMIO w < N_OPR, return operand w zero-extended to 32 bits; writes ignored.
REQ-021 SHALL, for MMIO w=16 (RESULT), push dataIn[RES_W-1:0] into the FIFO on write; reads return 0.
REQ-022 SHALL, for MMIO w=17 (STATUS), return {count in bits[22:16], overflow bit2, full bit1, empty bit0}, zeros elsewhere; writes ignored.
REQ-023 SHALL, for MMIO w=18 (CLEAR), empty the FIFO and clear overflow on write; reads return 0.
REQ-024 SHALL return 0 for any other MMIO read and ignore any other MMIO write.
REQ-025 SHALL drive result = FIFO head when result_valid=1, else 0 (never Z).
REQ-026 SHALL pop the head on an edge where result_valid=1 and result_ready=1.
REQ-027 SHALL accept a push when not full, or when full with a pop on the same edge; count is unchanged on simultaneous push+pop.
REQ-028 SHALL drop a push when full and not popping, and set sticky overflow; FIFO contents are unchanged.
REQ-029 SHALL give CLEAR priority over a simultaneous pop; the FIFO is empty after that edge.
REQ-030 SHALL make a pushed value visible on result one edge after the push (latency 1 edge).
REQ-031 SHALL wrap the FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-032 SHALL, on rst=1 at a falling edge, set the FIFO empty, overflow 0, result 0 and result_valid 0.
REQ-033 SHALL give rst priority over any write or pop in the same cycle.
REQ-034 SHALL leave RAM contents unaffected by reset; dataOut stays combinational.

Structure
REQ-035 SHALL take MMIO offsets (RESULT=16, STATUS=17, CLEAR=18), the MMIO select bit (15) and STATUS bit positions from package dram_mmio_pkg.
REQ-036 SHALL implement the FIFO as sub-module res_fifo (parameters width and depth; push/pop/clear/full/empty/count).

Verification
REQ-037 SHALL cover: write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 -> 0xDEADBEEF; read 0x0000_0410 (DEPTH=256) -> 0xDEADBEEF (wrap).
REQ-038 SHALL cover: opr={8'hA5,8'h3C}; read 0x8000 -> 0x3C, 0x8004 -> 0xA5, 0x8008 -> 0.
REQ-039 SHALL cover: result_ready=0; write 0x1234, 0x5678 to 0x8040 -> result=0x1234, STATUS=0x0002_0000; raise ready for 2 edges -> 0x5678 then result_valid=0, result=0.
REQ-040 SHALL cover: FIFO_DEPTH=4, ready=0, push 5 values -> full=1, overflow=1, count=4; the 5th value is never output.
REQ-041 SHALL cover: full FIFO, push 0x00AA with ready=1 on the same edge -> count stays 4, 0x00AA emerges 4th.
REQ-042 SHALL cover: two entries queued, assert rst for one edge -> result_valid=0, STATUS=0x1; RAM word written before reset is still readable.
